// File: rtl/tl_a_channel_arbiter.sv
// tl_a_channel_arbiter: round-robin TileLink A-channel arbiter with burst locking (rev 1.0).
// Define TL_A_ARB_OUT_REG_EN to register the manager side through a 2-entry skid buffer.
`default_nettype none

module tl_a_channel_arbiter #(
  parameter int N_CLIENTS  = 4,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int SOURCE_W   = 4,
  parameter int CID_W      = $clog2(N_CLIENTS),
  parameter int M_SOURCE_W = SOURCE_W + CID_W
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N_CLIENTS-1:0]            cli_a_valid_i,
  output logic [N_CLIENTS-1:0]            cli_a_ready_o,
  input  logic [3*N_CLIENTS-1:0]          cli_a_opcode_i,
  input  logic [3*N_CLIENTS-1:0]          cli_a_param_i,
  input  logic [4*N_CLIENTS-1:0]          cli_a_size_i,
  input  logic [N_CLIENTS*SOURCE_W-1:0]   cli_a_source_i,
  input  logic [N_CLIENTS*ADDR_W-1:0]     cli_a_address_i,
  input  logic [N_CLIENTS*DATA_W/8-1:0]   cli_a_mask_i,
  input  logic [N_CLIENTS*DATA_W-1:0]     cli_a_data_i,
  input  logic [N_CLIENTS-1:0]            cli_a_corrupt_i,
  output logic                            mgr_a_valid_o,
  input  logic                            mgr_a_ready_i,
  output logic [2:0]                      mgr_a_opcode_o,
  output logic [2:0]                      mgr_a_param_o,
  output logic [3:0]                      mgr_a_size_o,
  output logic [M_SOURCE_W-1:0]           mgr_a_source_o,
  output logic [ADDR_W-1:0]               mgr_a_address_o,
  output logic [DATA_W/8-1:0]             mgr_a_mask_o,
  output logic [DATA_W-1:0]               mgr_a_data_o,
  output logic                            mgr_a_corrupt_o,
  output logic                            busy_o,
  output logic [CID_W-1:0]                grant_idx_o
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PW = 3 + 3 + 4 + M_SOURCE_W + ADDR_W + MASK_W + DATA_W + 1;
  localparam logic [3:0] LOG_BPB = 4'($clog2(MASK_W));

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state, state_d;
  logic [CID_W-1:0]  rr_ptr, rr_ptr_d, grant_q, grant_d;
  logic [7:0]        beat_cnt, beat_cnt_d, first_total;
  logic [CID_W-1:0]  pick, cand;
  logic              found, last, busy, side_ready, cli_hs, sel_valid;
  logic [PW-1:0]     sel_pack, out_pack;

  logic [2:0]          opc_a [N_CLIENTS];
  logic [2:0]          par_a [N_CLIENTS];
  logic [3:0]          siz_a [N_CLIENTS];
  logic [SOURCE_W-1:0] src_a [N_CLIENTS];
  logic [ADDR_W-1:0]   adr_a [N_CLIENTS];
  logic [MASK_W-1:0]   msk_a [N_CLIENTS];
  logic [DATA_W-1:0]   dat_a [N_CLIENTS];

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_unpack
    assign opc_a[g] = cli_a_opcode_i[g*3 +: 3];
    assign par_a[g] = cli_a_param_i[g*3 +: 3];
    assign siz_a[g] = cli_a_size_i[g*4 +: 4];
    assign src_a[g] = cli_a_source_i[g*SOURCE_W +: SOURCE_W];
    assign adr_a[g] = cli_a_address_i[g*ADDR_W +: ADDR_W];
    assign msk_a[g] = cli_a_mask_i[g*MASK_W +: MASK_W];
    assign dat_a[g] = cli_a_data_i[g*DATA_W +: DATA_W];
  end

  // Data opcodes have opcode[2] clear; everything else is a single beat.
  function automatic logic [7:0] msg_beats(input logic [2:0] op, input logic [3:0] sz);
    logic [7:0] n;
    n = 8'd1;
    if (!op[2] && sz > LOG_BPB) n = 8'd1 << (sz - LOG_BPB);
    return n;
  endfunction

  assign busy        = (state == BUSY);
  assign busy_o      = busy;
  assign grant_idx_o = grant_q;
  assign sel_valid   = cli_a_valid_i[grant_q];
  assign cli_hs      = busy && sel_valid && side_ready;
  assign sel_pack    = {opc_a[grant_q], par_a[grant_q], siz_a[grant_q], grant_q, src_a[grant_q],
                        adr_a[grant_q], msk_a[grant_q], dat_a[grant_q], cli_a_corrupt_i[grant_q]};

  always_comb begin
    pick  = rr_ptr;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      cand = rr_ptr + CID_W'(i);
      if (!found && cli_a_valid_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    cli_a_ready_o = '0;
    if (busy) cli_a_ready_o[grant_q] = side_ready;
  end

  always_comb begin
    state_d     = state;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr;
    beat_cnt_d  = beat_cnt;
    first_total = 8'd0;
    last        = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cli_hs) begin
          // beat_cnt == 0 marks the first beat, whose fields size the message.
          if (beat_cnt == 8'd0) begin
            first_total = msg_beats(opc_a[grant_q], siz_a[grant_q]);
            last        = (first_total <= 8'd1);
            beat_cnt_d  = first_total - 8'd1;
          end else begin
            last       = (beat_cnt == 8'd1);
            beat_cnt_d = beat_cnt - 8'd1;
          end
          if (last) begin
            state_d    = IDLE;
            rr_ptr_d   = grant_q + 1'b1;
            beat_cnt_d = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      beat_cnt <= 8'd0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      grant_q  <= grant_d;
      beat_cnt <= beat_cnt_d;
    end
  end

`ifdef TL_A_ARB_OUT_REG_EN
  logic [PW-1:0] skid [2];
  logic          head, tail, push, pop;
  logic [1:0]    count;

  assign side_ready    = (count != 2'd2);
  assign push          = cli_hs;
  assign pop           = mgr_a_valid_o && mgr_a_ready_i;
  assign tail          = head ^ count[0];
  assign mgr_a_valid_o = (count != 2'd0);
  assign out_pack      = skid[head];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid[0] <= '0;
      skid[1] <= '0;
      head    <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) skid[tail] <= sel_pack;
      if (pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
`else
  assign side_ready    = mgr_a_ready_i;
  assign mgr_a_valid_o = busy && sel_valid;
  assign out_pack      = busy ? sel_pack : '0;
`endif

  assign {mgr_a_opcode_o, mgr_a_param_o, mgr_a_size_o, mgr_a_source_o,
          mgr_a_address_o, mgr_a_mask_o, mgr_a_data_o, mgr_a_corrupt_o} = out_pack;

endmodule

`default_nettype wire

// File: tb/tb_tl_a_channel_arbiter.sv
// Scoreboard bench for tl_a_channel_arbiter: directed client messages, monitor compares manager beats.
`timescale 1ns/1ps
`default_nettype none

module tb_tl_a_channel_arbiter;
  localparam int N = 4;
`ifdef TL_A_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  cli_a_valid, cli_a_ready, cli_a_corrupt;
  logic [3*N-1:0] cli_a_opcode, cli_a_param;
  logic [4*N-1:0] cli_a_size;
  logic [4*N-1:0] cli_a_source;
  logic [64*N-1:0] cli_a_address, cli_a_data;
  logic [8*N-1:0] cli_a_mask;
  logic          mgr_a_valid, mgr_a_ready, mgr_a_corrupt, busy;
  logic [2:0]    mgr_a_opcode, mgr_a_param;
  logic [3:0]    mgr_a_size;
  logic [5:0]    mgr_a_source;
  logic [63:0]   mgr_a_address, mgr_a_data;
  logic [7:0]    mgr_a_mask;
  logic [1:0]    grant_idx;

  tl_a_channel_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cli_a_valid_i(cli_a_valid), .cli_a_ready_o(cli_a_ready),
    .cli_a_opcode_i(cli_a_opcode), .cli_a_param_i(cli_a_param), .cli_a_size_i(cli_a_size),
    .cli_a_source_i(cli_a_source), .cli_a_address_i(cli_a_address),
    .cli_a_mask_i(cli_a_mask), .cli_a_data_i(cli_a_data), .cli_a_corrupt_i(cli_a_corrupt),
    .mgr_a_valid_o(mgr_a_valid), .mgr_a_ready_i(mgr_a_ready),
    .mgr_a_opcode_o(mgr_a_opcode), .mgr_a_param_o(mgr_a_param), .mgr_a_size_o(mgr_a_size),
    .mgr_a_source_o(mgr_a_source), .mgr_a_address_o(mgr_a_address), .mgr_a_mask_o(mgr_a_mask),
    .mgr_a_data_o(mgr_a_data), .mgr_a_corrupt_o(mgr_a_corrupt),
    .busy_o(busy), .grant_idx_o(grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  src;
    logic [63:0] addr;
    logic [2:0]  op;
    logic [3:0]  size;
    logic [63:0] data;
  } beat_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [3:0]  src;
    logic [63:0] addr;
    logic [63:0] base;
  } msg_t;

  beat_t        exp_q[$];
  msg_t         cq[N][$];
  msg_t         cur[N];
  bit           active[N];
  int           beat[N], nb[N];
  logic [N-1:0] hs_prev;
  int           tests = 0, fails = 0, cyc = 0;
  int           hs_cyc[$];
  int           t_cli[N];
  int           t_mgr, n_r2, n_rbad, n_r0;

  function automatic int beats_of(input logic [2:0] op, input logic [3:0] size);
    if (op < 3'd4 && size > 4'd3) return 1 << (size - 4'd3);
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_msg(input int c, input logic [2:0] op, input logic [3:0] size,
                          input logic [3:0] src, input logic [63:0] addr, input logic [63:0] base);
    msg_t m;
    beat_t e;
    m = '{op, size, src, addr, base};
    cq[c].push_back(m);
    for (int b = 0; b < beats_of(op, size); b++) begin
      e = '{{2'(c), src}, addr, op, size, base + 64'(b)};
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_all();
    for (int c = 0; c < N; c++) begin
      cli_a_valid[c]           = active[c];
      cli_a_opcode[c*3 +: 3]   = active[c] ? cur[c].op : 3'd0;
      cli_a_param[c*3 +: 3]    = 3'd0;
      cli_a_size[c*4 +: 4]     = active[c] ? cur[c].size : 4'd0;
      cli_a_source[c*4 +: 4]   = active[c] ? cur[c].src : 4'd0;
      cli_a_address[c*64 +: 64] = active[c] ? cur[c].addr : 64'd0;
      cli_a_mask[c*8 +: 8]     = 8'hFF;
      cli_a_data[c*64 +: 64]   = active[c] ? cur[c].base + 64'(beat[c]) : 64'd0;
      cli_a_corrupt[c]         = 1'b0;
    end
  endtask

  task automatic flush_clients();
    for (int c = 0; c < N; c++) begin
      active[c] = 1'b0;
      beat[c]   = 0;
      cq[c].delete();
    end
    drive_all();
  endtask

  task automatic clear_obs();
    for (int c = 0; c < N; c++) t_cli[c] = -1;
    t_mgr  = -1;
    n_r2   = 0;
    n_rbad = 0;
    n_r0   = 0;
    hs_cyc.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d beats outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc++;

  // Client model: beats advance on the handshake seen just before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      hs_prev = cli_a_valid & cli_a_ready;
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (hs_prev[c] && active[c]) begin
          beat[c]++;
          if (beat[c] >= nb[c]) active[c] = 1'b0;
        end
        if (!active[c] && cq[c].size() > 0) begin
          cur[c]    = cq[c].pop_front();
          beat[c]   = 0;
          nb[c]     = beats_of(cur[c].op, cur[c].size);
          active[c] = 1'b1;
        end
      end
      drive_all();
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < N; c++)
      if (cli_a_valid[c] && t_cli[c] < 0) t_cli[c] = cyc;
    if (mgr_a_valid && t_mgr < 0) t_mgr = cyc;
    if (cli_a_ready == 4'b0100) n_r2++;
    else if (cli_a_ready != 4'b0000) n_rbad++;
    if (cli_a_ready[0]) n_r0++;
  end

  always @(negedge clk) begin
    beat_t e, a;
    if (rst_n && mgr_a_valid && mgr_a_ready) begin
      hs_cyc.push_back(cyc);
      a = '{mgr_a_source, mgr_a_address, mgr_a_opcode, mgr_a_size, mgr_a_data};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: got %h, required no beat", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL beat_compare: got %h, required %h", a, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    mgr_a_ready = 1'b0;
    flush_clients();
    clear_obs();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mgr_valid", 64'(mgr_a_valid), 0);
    chk("rst_cli_ready", 64'(cli_a_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_source", 64'(mgr_a_source), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("idle_busy", 64'(busy), 0);
    chk("idle_grant", 64'(grant_idx), 0);

    // Single Get from client 2
    clear_obs();
    mgr_a_ready = 1'b1;
    push_msg(2, 3'd4, 4'd3, 4'd5, 64'h80, 64'hA0);
    drain("get", 20);
    chk("get_latency", 64'(t_mgr - t_cli[2]), 64'(LAT));
    chk("get_ready_cycles", 64'(n_r2), 1);
    chk("get_ready_other", 64'(n_rbad), 0);

    // Fairness after reset: 0,1,2,3,0 with one bubble between grants
    rst_n = 1'b0;
    flush_clients();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_obs();
    push_msg(0, 3'd6, 4'd6, 4'd1, 64'h100, 64'h10);
    push_msg(1, 3'd6, 4'd6, 4'd2, 64'h140, 64'h11);
    push_msg(2, 3'd6, 4'd6, 4'd3, 64'h180, 64'h12);
    push_msg(3, 3'd6, 4'd6, 4'd4, 64'h1C0, 64'h13);
    push_msg(0, 3'd6, 4'd6, 4'd6, 64'h200, 64'h14);
    drain("fair", 40);
    chk("fair_count", 64'(hs_cyc.size()), 5);
    for (int i = 0; i < 4; i++) chk("fair_gap", 64'(hs_cyc[i+1] - hs_cyc[i]), 2);

    // Burst lock: 8-beat put from client 1 while client 0 waits
    clear_obs();
    push_msg(1, 3'd0, 4'd6, 4'hA, 64'h1000, 64'h1000_0000);
    push_msg(0, 3'd4, 4'd3, 4'd1, 64'h40, 64'h77);
    drain("burst", 60);
    chk("burst_count", 64'(hs_cyc.size()), 9);
    for (int i = 0; i < 7; i++) chk("burst_gap", 64'(hs_cyc[i+1] - hs_cyc[i]), 1);
    chk("burst_to_c0_gap", 64'(hs_cyc[8] - hs_cyc[7]), 2);
    chk("burst_c0_ready", 64'(n_r0), 1);

    // Backpressure on client 3
    clear_obs();
    mgr_a_ready = 1'b0;
    push_msg(3, 3'd4, 4'd3, 4'hC, 64'h3000, 64'h33);
    n = 0;
    while (!mgr_a_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(mgr_a_valid), 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(mgr_a_valid), 1);
      chk("bp_address", mgr_a_address, 64'h3000);
      chk("bp_source", 64'(mgr_a_source), 64'h3C);
      chk("bp_grant", 64'(grant_idx), 3);
      chk("bp_cli_ready", 64'(cli_a_ready), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    mgr_a_ready = 1'b1;
    drain("bp", 20);

    // Reset while beat 3 of 8 is presented
    clear_obs();
    push_msg(2, 3'd0, 4'd6, 4'd7, 64'h2000, 64'h200);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(mgr_a_valid && mgr_a_data == 64'h202) && n < 30);
    chk("mid_burst_reached", 64'(mgr_a_data), 64'h202);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(mgr_a_valid), 0);
    chk("mrst_cli_ready", 64'(cli_a_ready), 0);
    chk("mrst_busy", 64'(busy), 0);
    chk("mrst_grant", 64'(grant_idx), 0);
    chk("mrst_data", mgr_a_data, 0);
    chk("mrst_source", 64'(mgr_a_source), 0);
    chk("mrst_remaining", 64'(exp_q.size()), 6);
    exp_q.delete();
    flush_clients();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_obs();
    push_msg(0, 3'd4, 4'd3, 4'd8, 64'h500, 64'h50);
    push_msg(1, 3'd4, 4'd3, 4'd9, 64'h540, 64'h51);
    push_msg(3, 3'd4, 4'd3, 4'hB, 64'h5C0, 64'h53);
    drain("post_reset", 30);

    // 8-beat put with manager ready toggling every cycle
    clear_obs();
    mgr_a_ready = 1'b1;
    push_msg(1, 3'd1, 4'd6, 4'd2, 64'h4000, 64'h400);
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(posedge clk);
      #2;
      mgr_a_ready = ~mgr_a_ready;
      n++;
    end
    mgr_a_ready = 1'b1;
    drain("toggle", 20);
    chk("toggle_latency", 64'(t_mgr - t_cli[1]), 64'(LAT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
